// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter encodings, BTB entry layout
// and the saturating-counter update helper.
package bp_pkg;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    // Tags are stored zero-extended to the widest possible (word address) width.
    localparam int BP_TAG_W = 30;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [31:0]         target;
    } btb_entry_t;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != BP_ST) nxt = cnt + 2'd1;
        end else begin
            if (cnt != BP_SNT) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped, tagged branch target buffer: one combinational read port,
// one write port. Ports carry word addresses (pc[31:2]).
module bp_btb
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] rd_word_i,
    output logic        rd_hit_o,
    output logic [31:0] rd_target_o,
    input  logic        wr_en_i,
    input  logic [29:0] wr_word_i,
    input  logic [31:0] wr_target_i
);

    localparam int IDX_W = $clog2(ENTRIES);

    btb_entry_t           mem_q [ENTRIES];
    logic [IDX_W-1:0]     rd_idx;
    logic [IDX_W-1:0]     wr_idx;
    logic [BP_TAG_W-1:0]  rd_tag;
    logic [BP_TAG_W-1:0]  wr_tag;

    assign rd_idx = rd_word_i[IDX_W-1:0];
    assign wr_idx = wr_word_i[IDX_W-1:0];
    assign rd_tag = rd_word_i >> IDX_W;
    assign wr_tag = wr_word_i >> IDX_W;

    assign rd_hit_o    = mem_q[rd_idx].valid && (mem_q[rd_idx].tag == rd_tag);
    assign rd_target_o = mem_q[rd_idx].target;

    // A write unconditionally replaces the slot, evicting any aliasing branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: wr_target_i};
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side dynamic branch predictor: 2-bit counter BHT plus tagged BTB, trained from EX.
// Define BP_GSHARE_EN to XOR a speculative global history into the BHT index.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16,
    parameter int GHR_BITS    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_valid,
    input  logic [31:0]         if_pc,
    output logic                pred_taken,
    output logic [31:0]         pred_target,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                ex_valid,
    input  logic [31:0]         ex_pc,
    input  logic                ex_branch_take,
    input  logic [31:0]         ex_target,
    input  logic                ex_pred_taken,
    input  logic [31:0]         ex_pred_target,
    input  logic [GHR_BITS-1:0] ex_ghr,
    output logic                ex_mispredict,
    output logic [31:0]         ex_redirect_pc
);

    localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]           bht_q [BHT_ENTRIES];
    logic [BHT_IDX_W-1:0] if_idx;
    logic [BHT_IDX_W-1:0] ex_idx;
    logic                 btb_hit;
    logic [31:0]          btb_target;

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q;
    logic [GHR_BITS-1:0] ghr_d;

    assign if_idx   = if_pc[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr_q);
    assign ex_idx   = ex_pc[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ex_ghr);
    assign pred_ghr = ghr_q;

    // Recovery from a mispredict outranks the speculative shift of the same cycle.
    always_comb begin
        ghr_d = ghr_q;
        if (ex_mispredict) begin
            ghr_d = {ex_ghr[GHR_BITS-2:0], ex_branch_take};
        end else if (if_valid) begin
            ghr_d = {ghr_q[GHR_BITS-2:0], pred_taken};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ghr_q <= '0;
        else        ghr_q <= ghr_d;
    end
`else
    logic unused_gshare;

    assign unused_gshare = if_valid ^ (^ex_ghr);
    assign if_idx        = if_pc[BHT_IDX_W+1:2];
    assign ex_idx        = ex_pc[BHT_IDX_W+1:2];
    assign pred_ghr      = '0;
`endif

    bp_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_word_i   (if_pc[31:2]),
        .rd_hit_o    (btb_hit),
        .rd_target_o (btb_target),
        .wr_en_i     (ex_valid & ex_branch_take),
        .wr_word_i   (ex_pc[31:2]),
        .wr_target_i (ex_target)
    );

    assign pred_taken  = btb_hit & bht_q[if_idx][1];
    assign pred_target = pred_taken ? btb_target : (if_pc + 32'd4);

    // ex_valid qualifies every EX input: nothing is compared or trained unless it is high.
    assign ex_mispredict  = ex_valid & ((ex_branch_take != ex_pred_taken) |
                                        (ex_branch_take & (ex_pred_target != ex_target)));
    assign ex_redirect_pc = ex_branch_take ? ex_target : (ex_pc + 32'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= BP_WNT;
            end
        end else if (ex_valid) begin
            bht_q[ex_idx] <= sat_update(bht_q[ex_idx], ex_branch_take);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_branch_predictor;

    localparam int BHT_N = 64;
    localparam int BTB_N = 16;
    localparam int GHR_W = 6;

    logic             clk;
    logic             rst_n;
    logic             if_valid;
    logic [31:0]      if_pc;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic [GHR_W-1:0] pred_ghr;
    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic             ex_branch_take;
    logic [31:0]      ex_target;
    logic             ex_pred_taken;
    logic [31:0]      ex_pred_target;
    logic [GHR_W-1:0] ex_ghr;
    logic             ex_mispredict;
    logic [31:0]      ex_redirect_pc;

    branch_predictor #(
        .BHT_ENTRIES (BHT_N),
        .BTB_ENTRIES (BTB_N),
        .GHR_BITS    (GHR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .pred_ghr       (pred_ghr),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_branch_take (ex_branch_take),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .ex_ghr         (ex_ghr),
        .ex_mispredict  (ex_mispredict),
        .ex_redirect_pc (ex_redirect_pc)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_cnt     [BHT_N];
    bit          m_btb_v   [BTB_N];
    logic [31:0] m_btb_pc  [BTB_N];
    logic [31:0] m_btb_tgt [BTB_N];
    int          m_ghr;

    int n_cmp;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int bht_slot(input logic [31:0] pc, input int ghr);
`ifdef BP_GSHARE_EN
        return int'(((pc >> 2) ^ ghr) % BHT_N);
`else
        return int'((pc >> 2) % BHT_N) + (ghr * 0);
`endif
    endfunction

    function automatic int btb_slot(input logic [31:0] pc);
        return int'((pc >> 2) % BTB_N);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int s;
        s = btb_slot(pc);
        return m_btb_v[s] && ((m_btb_pc[s] >> 2) == (pc >> 2));
    endfunction

    function automatic bit m_pred_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_cnt[bht_slot(pc, m_ghr)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
        return m_pred_taken(pc) ? m_btb_tgt[btb_slot(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_mispredict();
        return ex_valid && ((ex_branch_take != ex_pred_taken) ||
                            (ex_branch_take && (ex_pred_target != ex_target)));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BHT_N; i++) m_cnt[i] = 1;
        for (int i = 0; i < BTB_N; i++) begin
            m_btb_v[i]   = 1'b0;
            m_btb_pc[i]  = '0;
            m_btb_tgt[i] = '0;
        end
        m_ghr = 0;
    endtask

    task automatic model_clock();
        int  b;
        int  s;
        int  nghr;
        bit  pt;
        bit  mp;
        if (!rst_n) return;
        pt   = m_pred_taken(if_pc);
        mp   = m_mispredict();
        nghr = m_ghr;
        if (mp) nghr = ((int'(ex_ghr) << 1) | int'(ex_branch_take)) % (1 << GHR_W);
        else if (if_valid) nghr = ((m_ghr << 1) | int'(pt)) % (1 << GHR_W);
        if (ex_valid) begin
            b = bht_slot(ex_pc, int'(ex_ghr));
            if (ex_branch_take) begin
                if (m_cnt[b] < 3) m_cnt[b]++;
                s = btb_slot(ex_pc);
                m_btb_v[s]   = 1'b1;
                m_btb_pc[s]  = ex_pc;
                m_btb_tgt[s] = ex_target;
            end else begin
                if (m_cnt[b] > 0) m_cnt[b]--;
            end
        end
`ifdef BP_GSHARE_EN
        m_ghr = nghr;
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply(input bit ifv, input logic [31:0] ifpc, input bit exv,
                         input logic [31:0] expc, input bit take, input logic [31:0] tgt,
                         input bit ept, input logic [31:0] eptgt, input logic [GHR_W-1:0] eghr);
        if_valid       = ifv;
        if_pc          = ifpc;
        ex_valid       = exv;
        ex_pc          = expc;
        ex_branch_take = take;
        ex_target      = tgt;
        ex_pred_taken  = ept;
        ex_pred_target = eptgt;
        ex_ghr         = eghr;
    endtask

    task automatic fetch_only(input logic [31:0] pc);
        apply(1'b0, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, '0);
    endtask

    // Resolve a branch whose IF-stage prediction matched the model's current prediction.
    task automatic train(input logic [31:0] pc, input bit take, input logic [31:0] tgt);
        apply(1'b0, pc, 1'b1, pc, take, tgt, m_pred_taken(pc), m_pred_target(pc),
              GHR_W'(m_ghr));
    endtask

    task automatic sample();
        @(negedge clk);
        check("pred_taken",     {31'b0, pred_taken},    {31'b0, m_pred_taken(if_pc)});
        check("pred_target",    pred_target,            m_pred_target(if_pc));
        check("pred_ghr",       32'(pred_ghr),          32'(m_ghr));
        check("ex_mispredict",  {31'b0, ex_mispredict}, {31'b0, m_mispredict()});
        check("ex_redirect_pc", ex_redirect_pc,         ex_branch_take ? ex_target : ex_pc + 32'd4);
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic cycle();
        sample();
        tick();
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] pc_pool  [8];
    logic [31:0] tgt_pool [4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        pc_pool  = '{32'h100, 32'h140, 32'h104, 32'h200, 32'h3fc, 32'h1000, 32'h1040, 32'hfffffffc};
        tgt_pool = '{32'h80, 32'h90, 32'h800, 32'h1000};

        rst_n = 1'b0;
        fetch_only(32'h100);
        model_reset();
        repeat (3) @(posedge clk);
        #1;

        // Reset state and test 1.
        sample();
        check("rst_pred_taken",  {31'b0, pred_taken},    32'd0);
        check("rst_pred_target", pred_target,            32'h104);
        check("rst_pred_ghr",    32'(pred_ghr),          32'd0);
        check("rst_mispredict",  {31'b0, ex_mispredict}, 32'd0);
        rst_n = 1'b1;
        tick();

`ifndef BP_GSHARE_EN
        // Test 2: first taken resolution allocates the BTB.
        apply(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, '0);
        sample();
        check("t2_mispredict", {31'b0, ex_mispredict}, 32'd1);
        check("t2_redirect",   ex_redirect_pc,         32'h80);
        tick();
        fetch_only(32'h100);
        sample();
        check("t2_taken",  {31'b0, pred_taken}, 32'd1);
        check("t2_target", pred_target,         32'h80);
        tick();

        // Test 3: saturate high, then two not-taken resolutions.
        repeat (3) begin train(32'h100, 1'b1, 32'h80); cycle(); end
        train(32'h100, 1'b0, 32'h80); cycle();
        fetch_only(32'h100);
        sample();
        check("t3_taken_after_1nt", {31'b0, pred_taken}, 32'd1);
        check("t3_target_1nt",      pred_target,         32'h80);
        tick();
        train(32'h100, 1'b0, 32'h80); cycle();
        fetch_only(32'h100);
        sample();
        check("t3_taken_after_2nt", {31'b0, pred_taken}, 32'd0);
        check("t3_target_2nt",      pred_target,         32'h104);
        tick();

        // Test 4: predicted taken to the wrong target.
        train(32'h100, 1'b1, 32'h80); cycle();
        apply(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80, '0);
        sample();
        check("t4_mispredict", {31'b0, ex_mispredict}, 32'd1);
        check("t4_redirect",   ex_redirect_pc,         32'h90);
        tick();
        fetch_only(32'h100);
        sample();
        check("t4_target", pred_target, 32'h90);
        tick();

        // Test 5: 0x140 evicts 0x100 from the shared BTB slot.
        train(32'h140, 1'b1, 32'h200); cycle();
        fetch_only(32'h100);
        sample();
        check("t5_alias_taken",  {31'b0, pred_taken}, 32'd0);
        check("t5_alias_target", pred_target,         32'h104);
        tick();
        fetch_only(32'h140);
        sample();
        check("t5_owner_target", pred_target, 32'h200);
        tick();

        // Lower saturation: four not-taken pin the counter at 00.
        repeat (4) begin train(32'h140, 1'b0, 32'h200); cycle(); end
        train(32'h140, 1'b1, 32'h200); cycle();
        fetch_only(32'h140);
        sample();
        check("sat_low_taken", {31'b0, pred_taken}, 32'd0);
        tick();
        train(32'h140, 1'b1, 32'h200); cycle();
        fetch_only(32'h140);
        sample();
        check("sat_low_retaken", {31'b0, pred_taken}, 32'd1);
        tick();
`else
        // Test 6: recovery wins over a simultaneous speculative shift.
        apply(1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 32'h400, 1'b0, 32'h304, 6'b000001);
        sample();
        check("t6_mispredict", {31'b0, ex_mispredict}, 32'd1);
        tick();
        fetch_only(32'h300);
        sample();
        check("t6_ghr", 32'(pred_ghr), 32'h3);
        tick();
`endif

        // Reset asserted while a training write is pending.
        apply(1'b1, 32'h500, 1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 32'h504, '0);
        #2;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        fetch_only(32'h500);
        sample();
        check("midrst_taken",      {31'b0, pred_taken},    32'd0);
        check("midrst_target",     pred_target,            32'h504);
        check("midrst_ghr",        32'(pred_ghr),          32'd0);
        check("midrst_mispredict", {31'b0, ex_mispredict}, 32'd0);
        rst_n = 1'b1;
        tick();
        fetch_only(32'h500);
        sample();
        check("midrst_dropped", {31'b0, pred_taken}, 32'd0);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ipc;
            logic [31:0] epc;
            logic [31:0] tgt;
            ipc = pc_pool[$urandom_range(0, 7)];
            epc = pc_pool[$urandom_range(0, 7)];
            tgt = tgt_pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 1) == 1)
                apply(1'($urandom_range(0, 1)), ipc, $urandom_range(0, 3) != 0, epc,
                      1'($urandom_range(0, 1)), tgt, m_pred_taken(epc), m_pred_target(epc),
                      GHR_W'($urandom_range(0, 63)));
            else
                apply(1'($urandom_range(0, 1)), ipc, $urandom_range(0, 3) != 0, epc,
                      1'($urandom_range(0, 1)), tgt, 1'($urandom_range(0, 1)),
                      tgt_pool[$urandom_range(0, 3)], GHR_W'($urandom_range(0, 63)));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

- Instruction-fetch-side dynamic branch predictor for the 5-stage pipeline.
- Fetch: predicts direction and target for the PC being fetched.
- Execute: trains on the resolved outcome from the branch comparator (`branch_take`).
- Execute: flags mispredictions and supplies the corrected fetch PC to the PC-select logic.
- Hardware: 2-bit saturating-counter BHT plus a direct-mapped, tagged BTB.

## Interface
Parameters:
- `BHT_ENTRIES`, 64, number of 2-bit counters; power of two.
- `BTB_ENTRIES`, 16, number of BTB entries; power of two.
- `GHR_BITS`, 6, global history length; must be ≤ log2(`BHT_ENTRIES`). Used only with `BP_GSHARE_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_valid` in 1: fetch PC valid this cycle (fetch advances).
- `if_pc` in 32: fetch PC.
- `pred_taken` out 1: predicted taken.
- `pred_target` out 32: predicted target; `if_pc+4` when `pred_taken`=0.
- `pred_ghr` out `GHR_BITS`: history snapshot; travels down the pipe with the instruction.
- `ex_valid` in 1: a conditional branch is resolving in EX (`is_branch` and not flushed).
- `ex_pc` in 32: PC of the resolving branch.
- `ex_branch_take` in 1: comparator result.
- `ex_target` in 32: computed branch target.
- `ex_pred_taken` in 1: `pred_taken` carried from IF.
- `ex_pred_target` in 32: `pred_target` carried from IF.
- `ex_ghr` in `GHR_BITS`: `pred_ghr` carried from IF.
- `ex_mispredict` out 1: redirect and flush request.
- `ex_redirect_pc` out 32: correct next PC.

## Operation
Indexing:
- BHT index = `pc[log2(BHT_ENTRIES)+1:2]`.
- BTB index = `pc[log2(BTB_ENTRIES)+1:2]`.
- BTB tag = `pc[31:log2(BTB_ENTRIES)+2]`.

Predict (combinational from `if_pc`):
- `hit` = BTB valid and tag matches.
- `pred_taken` = `hit` & counter[1].
- `pred_target` = BTB target if `pred_taken`, else `if_pc+4` (32-bit add, wraps modulo 2^32).

Resolve (combinational):
- `ex_mispredict` = `ex_valid` & ((`ex_branch_take` != `ex_pred_taken`) | (`ex_branch_take` & `ex_pred_target` != `ex_target`)).
- `ex_redirect_pc` = `ex_branch_take` ? `ex_target` : `ex_pc+4`.
- `ex_mispredict` = 0 whenever `ex_valid` = 0.

Train (clock edge when `ex_valid`):
- Counter update: taken increments, saturating at 2'b11; not-taken decrements, saturating at 2'b00.
- BTB write (valid, tag, `ex_target`) only when taken; overwrites any existing entry.
- Not-taken branches never allocate or invalidate BTB entries.

Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

## Timing
- Prediction: zero-cycle (combinational) from `if_pc`. Tables are flop arrays; no SRAM read latency.
- Training: takes effect at the rising edge ending the `ex_valid` cycle.
- Same-cycle predict/train of the same entry: predict sees the old value (no write-to-read bypass).
- Asynchronous reset:
  - all counters to 2'b01;
  - all BTB valid bits to 0;
  - GHR to 0.
  - Resulting output values: `pred_taken`=0, `pred_target`=`if_pc+4`, `pred_ghr`=0, `ex_mispredict`=0 (requires `ex_valid`=0 during reset).
- Reset asserted mid-training: the write is dropped; reset values hold.

## Configuration
Macro `BP_GSHARE_EN`.

Defined:
- BHT index = PC index XOR zero-extended GHR.
- Speculative GHR update: when `if_valid`, GHR shifts left, inserting `pred_taken`.
- On `ex_mispredict`, GHR loads {`ex_ghr[GHR_BITS-2:0]`, `ex_branch_take`}. Mispredict recovery has priority over a same-cycle speculative shift.
- Training uses the index recomputed from `ex_pc` and `ex_ghr`.
- `pred_ghr` = current GHR.

Undefined:
- Plain bimodal indexing; no GHR flops.
- `pred_ghr` tied to 0; `ex_ghr` ignored.

## Structure
- Package `bp_pkg`:
  - counter encoding constants `BP_SNT`, `BP_WNT`, `BP_WT`, `BP_ST`;
  - typedef `btb_entry_t` {valid, tag, target};
  - function `sat_update(cnt, taken)`.
- One sub-module `bp_btb`: tagged direct-mapped array with one combinational read port and one write port.
- BHT, GHR and resolve logic stay in the top module.

## Test plan
1. Reset, then `if_pc`=0x100 → `pred_taken`=0, `pred_target`=0x104.
2. Branch at 0x100, target 0x80, resolved taken once with `ex_pred_taken`=0 → `ex_mispredict`=1, `ex_redirect_pc`=0x80. Next fetch of 0x100 → `pred_taken`=1, `pred_target`=0x80.
3. Same branch trained taken ×3, then not-taken ×1 → still `pred_taken`=1 (counter 10). Second not-taken → `pred_taken`=0.
4. Predicted taken to 0x80 but `ex_target`=0x90 → `ex_mispredict`=1, `ex_redirect_pc`=0x90. BTB now returns 0x90.
5. Aliasing: PCs 0x100 and 0x140 (`BTB_ENTRIES`=16) share a BTB index. Train 0x140 taken → fetch of 0x100 misses the tag, `pred_taken`=0.
6. `BP_GSHARE_EN`: mispredict and `if_valid` in the same cycle with `ex_ghr`=6'b000001, `ex_branch_take`=1 → GHR=6'b000011 next cycle. Assert `rst_n` low mid-run → all outputs return to reset values.
